// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: shift-add MULT and restoring DIV, one bit per cycle,
// with a start/busy/done handshake and an explicit divide-by-zero flag.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q;
  logic               op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic               zero_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic [WIDTH-1:0]   mag_b_q;
  // MULT: {partial product, remaining multiplier bits}; DIV: low half shifts dividend out, quotient in
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     rem_q;
  logic [CntW-1:0]    cnt_q;

  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH+1:0]   shifted;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    mag_a_in = a[WIDTH-1] ? -a : a;
    mag_b_in = b[WIDTH-1] ? -b : b;
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    shifted  = {rem_q, acc_q[WIDTH-1]};
    trial    = shifted - {2'b00, mag_b_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      zero_q   <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= op;
            sign_a_q <= a[WIDTH-1];
            sign_b_q <= b[WIDTH-1];
            zero_q   <= (b == '0);
            mag_a_q  <= mag_a_in;
            mag_b_q  <= mag_b_in;
            acc_q    <= {{WIDTH{1'b0}}, (op ? mag_a_in : mag_b_in)};
            rem_q    <= '0;
            cnt_q    <= CntW'(WIDTH);
            busy     <= 1'b1;
            state_q  <= (op && (b == '0)) ? StFix : StRun;
          end
        end
        StRun: begin
          if (op_q) begin
            // Restore when the trial subtraction borrows
            acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], ~trial[WIDTH+1]};
            rem_q            <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
          end else begin
            acc_q <= {add_sum, acc_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (op_q && zero_q) begin
            div_zero <= 1'b1;
          end else if (op_q) begin
            hi       <= rem_fix;
            lo       <= quot_fix;
            div_zero <= 1'b0;
          end else begin
            hi       <= prod_fix[2*WIDTH-1:WIDTH];
            lo       <= prod_fix[WIDTH-1:0];
            div_zero <= 1'b0;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: WIDTH=32 and WIDTH=8 instances checked against an
// arithmetic reference model, including latency, busy, divide-by-zero and async reset.
module tb_mult_div_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start32 = 1'b0, op32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0, op8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
    int          cyc;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] mhi32 = '0, mlo32 = '0, mhi8 = '0, mlo8 = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic longint sext(input logic [31:0] v, input int w);
    longint x;
    x = longint'({32'b0, v & wmask(w)});
    if (v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Plain signed arithmetic: SV division truncates toward zero, remainder takes dividend sign
  task automatic ref_model(input bit op, input logic [31:0] a, input logic [31:0] b,
                           input int w, input logic [31:0] phi, input logic [31:0] plo,
                           output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint      sa, sb, p, q, r;
    logic [63:0] pu;
    sa = sext(a, w);
    sb = sext(b, w);
    dz = 1'b0;
    if (!op) begin
      p  = sa * sb;
      pu = p;
      lo = pu[31:0] & wmask(w);
      hi = 32'(pu >> w) & wmask(w);
    end else if (sb == 0) begin
      hi = phi;
      lo = plo;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = 32'(q) & wmask(w);
      hi = 32'(r) & wmask(w);
    end
  endtask

  task automatic issue(input bit w8, input bit op, input logic [31:0] a, input logic [31:0] b);
    int   budget = 0;
    int   w;
    exp_t e;
    w = w8 ? 8 : 32;
    @(negedge clock);
    while ((w8 ? busy8 : busy32) && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (budget >= 200) chk(w8 ? "wait_idle8" : "wait_idle32", 32'd1, 32'd0);
    if (w8) ref_model(op, a, b, w, mhi8, mlo8, e.hi, e.lo, e.dz);
    else    ref_model(op, a, b, w, mhi32, mlo32, e.hi, e.lo, e.dz);
    e.cyc = cyc + ((op && ((b & wmask(w)) == 0)) ? 2 : w + 2);
    if (w8) begin
      op8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
      mhi8 = e.hi; mlo8 = e.lo;
    end else begin
      op32 = op; a32 = a; b32 = b; start32 = 1'b1;
      mhi32 = e.hi; mlo32 = e.lo;
    end
    @(posedge clock);
    if (w8) q8.push_back(e);
    else    q32.push_back(e);
    #1;
    if (w8) start8 = 1'b0;
    else    start32 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(q32.size() + q8.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h1 << (w - 1);
      3:       v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v & wmask(w);
  endfunction

  always @(negedge clock) begin : mon32
    exp_t e;
    if (!reset) begin
      if (done32) begin
        if (q32.size() == 0) begin
          chk("done32_unexpected", 32'd1, 32'd0);
        end else begin
          e = q32.pop_front();
          chk("hi32", hi32, e.hi);
          chk("lo32", lo32, e.lo);
          chk("div_zero32", 32'(dz32), 32'(e.dz));
          chk("latency32", 32'(cyc), 32'(e.cyc));
          chk("busy32_in_done", 32'(busy32), 32'd0);
        end
      end else if (q32.size() != 0) begin
        chk("busy32", 32'(busy32), 32'd1);
      end
    end
  end

  always @(negedge clock) begin : mon8
    exp_t e;
    if (!reset) begin
      if (done8) begin
        if (q8.size() == 0) begin
          chk("done8_unexpected", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          chk("hi8", {24'b0, hi8}, e.hi);
          chk("lo8", {24'b0, lo8}, e.lo);
          chk("div_zero8", 32'(dz8), 32'(e.dz));
          chk("latency8", 32'(cyc), 32'(e.cyc));
          chk("busy8_in_done", 32'(busy8), 32'd0);
        end
      end else if (q8.size() != 0) begin
        chk("busy8", 32'(busy8), 32'd1);
      end
    end
  end

  initial begin
    #1;
    chk("rst_busy32", 32'(busy32), 32'd0);
    chk("rst_done32", 32'(done32), 32'd0);
    chk("rst_hi32", hi32, 32'd0);
    chk("rst_lo32", lo32, 32'd0);
    chk("rst_dz32", 32'(dz32), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_hilo8", {16'b0, hi8, lo8}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    issue(0, 0, 32'd7, 32'hFFFF_FFFD);
    issue(0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    issue(0, 1, 32'hFFFF_FFF9, 32'd2);
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(0, 1, 32'h451, 32'h20);
    issue(0, 1, 32'd5, 32'd0);
    issue(0, 0, 32'd1, 32'd1);
    issue(1, 0, 32'h80, 32'h80);
    issue(1, 1, 32'd100, 32'hF9);

    for (int i = 0; i < 40; i++) begin
      issue(0, 1'($urandom_range(0, 1)), pick(32), pick(32));
      issue(1, 1'($urandom_range(0, 1)), pick(8), pick(8));
    end
    drain();

    // A second start while RUN must be ignored
    issue(0, 0, 32'd3, 32'd4);
    repeat (9) @(posedge clock);
    #1;
    start32 = 1'b1; op32 = 1'b1; b32 = 32'd0;
    @(posedge clock);
    #1;
    start32 = 1'b0;
    drain();

    issue(0, 0, 32'h1234_5678, 32'h09AB_CDEF);
    repeat (15) @(posedge clock);
    #3;
    reset = 1'b1;
    q32.delete();
    q8.delete();
    mhi32 = '0; mlo32 = '0; mhi8 = '0; mlo8 = '0;
    #1;
    chk("midrst_busy32", 32'(busy32), 32'd0);
    chk("midrst_done32", 32'(done32), 32'd0);
    chk("midrst_hi32", hi32, 32'd0);
    chk("midrst_lo32", lo32, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    issue(0, 0, 32'd2, 32'd2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
